// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter.
//   XLEN           : datapath width used by the stored long-latency entries
//   ctrl_signals_t : W-stage control bundle (only the writeback fields)
//   ll_entry_t     : one long-latency completion {rd, data}
//   wb_grant_t     : owner of the register-file write port in a cycle
package wb_arbiter_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic is_Uinstr;
    logic is_J_Rd;
  } ctrl_signals_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ll_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LL
  } wb_grant_t;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_arbiter_ll_fifo.sv
// Completion FIFO for one long-latency channel, with a head age counter
// and a per-register busy vector covering every entry it holds.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : enqueue {i_rd, i_data} (ignored when full or in reset)
//   i_pop        : dequeue the head (ignored when empty)
//   o_ready      : FIFO can accept an entry this cycle
//   o_empty      : no entry held
//   o_head_rd/o_head_data : current head entry
//   o_age        : cycles the head has waited, saturating at STARVE_LIMIT
//   o_count      : occupancy
//   o_busy       : onehot(rd) OR-ed over all held entries
module ll_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_push,
  input  logic [4:0]                       i_rd,
  input  logic [XLEN-1:0]                  i_data,
  input  logic                             i_pop,
  output logic                             o_ready,
  output logic                             o_empty,
  output logic [4:0]                       o_head_rd,
  output logic [XLEN-1:0]                  o_head_data,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] o_age,
  output logic [$clog2(DEPTH+1)-1:0]       o_count,
  output logic [31:0]                      o_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(STARVE_LIMIT+1);

  ll_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    r_age;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // Ready comes from the registered count only, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign o_ready = ~w_full & ~rst;
  assign w_push  = i_push & o_ready;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: the payload array has no reset; r_vld alone says which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{rd: i_rd, data: i_data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + PW'(1);
        r_vld[r_rd_ptr] <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // A fresh head (after a pop, or pushed into an empty FIFO) starts at 0.
      if (w_pop || o_empty)                r_age <= '0;
      else if (r_age != AW'(STARVE_LIMIT)) r_age <= r_age + AW'(1);
    end
  end

  assign o_head_rd   = r_mem[r_rd_ptr].rd;
  assign o_head_data = r_mem[r_rd_ptr].data;
  assign o_age       = r_age;
  assign o_count     = r_count;

  always_comb begin
    o_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) o_busy |= rd_onehot(r_mem[i].rd);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: selects the in-order pipe result and arbitrates it with
// N_LL long-latency completion channels for the single register-file port.
//   clk, rst            : clock, asynchronous active-high reset
//   wb_valid_W, ctrl_signals_W, rd_W, alu_result_W, data_load_ext_W,
//   se_immediate_W, pc_plus_4_W : W-stage instruction and its candidate results
//   ll_valid/ll_ready/ll_rd/ll_data : per-channel completion handshake (flat)
//   rf_we, rf_rd, rf_data : register-file write port
//   stall_W             : freeze W and upstream while a starved head drains
//   ll_busy_rd          : registers with an outstanding long-latency write
//   ll_pending          : per-channel FIFO occupancy (flat)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN         = wb_arbiter_pkg::XLEN,
  parameter int N_LL         = 2,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wb_valid_W,
  input  ctrl_signals_t                     ctrl_signals_W,
  input  logic [4:0]                        rd_W,
  input  logic [XLEN-1:0]                   alu_result_W,
  input  logic [XLEN-1:0]                   data_load_ext_W,
  input  logic [XLEN-1:0]                   se_immediate_W,
  input  logic [XLEN-1:0]                   pc_plus_4_W,
  input  logic [N_LL-1:0]                   ll_valid,
  output logic [N_LL-1:0]                   ll_ready,
  input  logic [N_LL*5-1:0]                 ll_rd,
  input  logic [N_LL*XLEN-1:0]              ll_data,
  output logic                              rf_we,
  output logic [4:0]                        rf_rd,
  output logic [XLEN-1:0]                   rf_data,
  output logic                              stall_W,
  output logic [31:0]                       ll_busy_rd,
  output logic [N_LL*$clog2(DEPTH+1)-1:0]   ll_pending
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(STARVE_LIMIT+1);
  localparam int IW = (N_LL > 1) ? $clog2(N_LL) : 1;

  logic [N_LL-1:0] w_push;
  logic [N_LL-1:0] w_pop;
  logic [N_LL-1:0] w_empty;
  logic [4:0]      w_head_rd   [N_LL];
  logic [XLEN-1:0] w_head_data [N_LL];
  logic [AW-1:0]   w_age       [N_LL];
  logic [31:0]     w_busy      [N_LL];
  logic [31:0]     w_busy_all;

  logic [XLEN-1:0] w_pipe_data;
  logic            w_pipe_req;
  logic            w_starved_any;
  wb_grant_t       w_grant;
  logic [IW-1:0]   w_ll_sel;
  logic [IW-1:0]   r_rr_ptr;

  assign w_push = ll_valid & ll_ready;

  for (genvar g = 0; g < N_LL; g++) begin : g_ch
    ll_fifo #(
      .DEPTH       (DEPTH),
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push[g]),
      .i_rd       (ll_rd[g*5 +: 5]),
      .i_data     (ll_data[g*XLEN +: XLEN]),
      .i_pop      (w_pop[g]),
      .o_ready    (ll_ready[g]),
      .o_empty    (w_empty[g]),
      .o_head_rd  (w_head_rd[g]),
      .o_head_data(w_head_data[g]),
      .o_age      (w_age[g]),
      .o_count    (ll_pending[g*CW +: CW]),
      .o_busy     (w_busy[g])
    );
  end

  assign w_pipe_data = ctrl_signals_W.is_J_Rd    ? pc_plus_4_W     :
                       ctrl_signals_W.is_Uinstr  ? se_immediate_W  :
                       ctrl_signals_W.mem_to_reg ? data_load_ext_W : alu_result_W;

  // Held off in reset so no write leaks out while the stage is being cleared.
  assign w_pipe_req = wb_valid_W & ctrl_signals_W.reg_write & (rd_W != 5'd0) & ~rst;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % N_LL);
  endfunction

  // Arbiter: starved heads first, then the pipe, then round-robin.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    w_grant       = GNT_NONE;
    w_ll_sel      = '0;
    w_starved_any = 1'b0;
    // Scanning downwards leaves the lowest starved index selected.
    for (int i = N_LL - 1; i >= 0; i--) begin
      if (w_age[i] == AW'(STARVE_LIMIT)) begin
        w_starved_any = 1'b1;
        w_ll_sel      = IW'(i);
      end
    end
    if (w_starved_any) begin
      w_grant = GNT_LL;
    end else if (w_pipe_req) begin
      w_grant = GNT_PIPE;
    end else begin
      // Downwards over the offset so the nearest channel after r_rr_ptr wins.
      for (int k = N_LL; k >= 1; k--) begin
        if (!w_empty[rr_idx(r_rr_ptr, k)]) begin
          w_grant  = GNT_LL;
          w_ll_sel = rr_idx(r_rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_grant == GNT_LL) w_pop[w_ll_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_rr_ptr <= '0;
    else if (w_grant == GNT_LL) r_rr_ptr <= w_ll_sel;
  end

  // An LL head with rd==0 still pops but produces no write.
  always_comb begin
    rf_we   = 1'b0;
    rf_rd   = '0;
    rf_data = '0;
    unique case (w_grant)
      GNT_PIPE: begin
        rf_we   = 1'b1;
        rf_rd   = rd_W;
        rf_data = w_pipe_data;
      end
      GNT_LL: begin
        if (w_head_rd[w_ll_sel] != 5'd0) begin
          rf_we   = 1'b1;
          rf_rd   = w_head_rd[w_ll_sel];
          rf_data = w_head_data[w_ll_sel];
        end
      end
      default: ;
    endcase
  end

  assign stall_W = w_starved_any;

  always_comb begin
    w_busy_all = '0;
    for (int i = 0; i < N_LL; i++) w_busy_all |= w_busy[i];
  end

  assign ll_busy_rd = {w_busy_all[31:1], 1'b0};

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N_LL         = 2;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(DEPTH+1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 wb_valid_W;
  ctrl_signals_t        ctrl_signals_W;
  logic [4:0]           rd_W;
  logic [XLEN-1:0]      alu_result_W, data_load_ext_W, se_immediate_W, pc_plus_4_W;
  logic [N_LL-1:0]      ll_valid, ll_ready;
  logic [N_LL*5-1:0]    ll_rd;
  logic [N_LL*XLEN-1:0] ll_data;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_data;
  logic                 stall_W;
  logic [31:0]          ll_busy_rd;
  logic [N_LL*CW-1:0]   ll_pending;

  wb_arbiter #(
    .XLEN(XLEN), .N_LL(N_LL), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .wb_valid_W(wb_valid_W), .ctrl_signals_W(ctrl_signals_W),
    .rd_W(rd_W), .alu_result_W(alu_result_W), .data_load_ext_W(data_load_ext_W),
    .se_immediate_W(se_immediate_W), .pc_plus_4_W(pc_plus_4_W),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data), .stall_W(stall_W),
    .ll_busy_rd(ll_busy_rd), .ll_pending(ll_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 rst;
    logic                 valid;
    ctrl_signals_t        ctrl;
    logic [4:0]           rd;
    logic [XLEN-1:0]      alu, ld, imm, pc4;
    logic [N_LL-1:0]      llv;
    logic [N_LL*5-1:0]    llrd;
    logic [N_LL*XLEN-1:0] lld;
  } stim_t;

  typedef struct {
    logic               we;
    logic [4:0]         rd;
    logic [XLEN-1:0]    data;
    logic               stall;
    logic [N_LL-1:0]    ready;
    logic [31:0]        busy;
    logic [N_LL*CW-1:0] pending;
  } exp_t;

  // Reference model: one queue per channel, head waiting time, last LL winner.
  exp_t      sb[$];
  ll_entry_t mq[N_LL][$];
  int        m_age[N_LL];
  int        m_last;
  bit        m_stall_prev;
  stim_t     m_held;

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("rf_we",      64'(rf_we),      64'(e.we));
        check("rf_rd",      64'(rf_rd),      64'(e.rd));
        check("rf_data",    64'(rf_data),    64'(e.data));
        check("stall_W",    64'(stall_W),    64'(e.stall));
        check("ll_ready",   64'(ll_ready),   64'(e.ready));
        check("ll_busy_rd", 64'(ll_busy_rd), 64'(e.busy));
        check("ll_pending", 64'(ll_pending), 64'(e.pending));
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.valid = 1'b0; s.ctrl = '0; s.rd = '0;
    s.alu = '0; s.ld = '0; s.imm = '0; s.pc4 = '0;
    s.llv = '0; s.llrd = '0; s.lld = '0;
    return s;
  endfunction

  function automatic stim_t with_ll(input stim_t s_in, input int ch,
                                    input logic [4:0] rd, input logic [XLEN-1:0] d);
    stim_t s;
    s = s_in;
    s.llv[ch] = 1'b1;
    s.llrd[ch*5 +: 5] = rd;
    s.lld[ch*XLEN +: XLEN] = d;
    return s;
  endfunction

  // Pipe instruction that always requests a write.
  function automatic stim_t pipe_w(input int n);
    stim_t s;
    s = idle();
    s.valid = 1'b1;
    s.ctrl  = ctrl_signals_t'($urandom_range(0, 15));
    s.ctrl.reg_write = 1'b1;
    s.rd  = 5'(1 + (n % 31));
    s.alu = $urandom; s.ld = $urandom; s.imm = $urandom; s.pc4 = $urandom;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.valid = ($urandom_range(0, 1) == 1);
    s.ctrl  = ctrl_signals_t'($urandom_range(0, 15));
    s.rd  = 5'($urandom_range(0, 31));
    s.alu = $urandom; s.ld = $urandom; s.imm = $urandom; s.pc4 = $urandom;
    for (int i = 0; i < N_LL; i++) begin
      if ($urandom_range(0, 9) < 3) s = with_ll(s, i, 5'($urandom_range(0, 7)), $urandom);
    end
    return s;
  endfunction

  task automatic cycle(input stim_t s_in);
    stim_t           s;
    exp_t            e;
    int              sel;
    bit              pipe_req;
    bit              ll_gnt;
    bit [N_LL-1:0]   rdy;
    s = s_in;
    if (s.rst) begin
      for (int i = 0; i < N_LL; i++) begin
        mq[i].delete();
        m_age[i] = 0;
      end
      m_last = 0;
      m_stall_prev = 1'b0;
    end else if (m_stall_prev) begin
      // A stalled W instruction is presented again unchanged.
      s.valid = m_held.valid; s.ctrl = m_held.ctrl; s.rd = m_held.rd;
      s.alu = m_held.alu; s.ld = m_held.ld; s.imm = m_held.imm; s.pc4 = m_held.pc4;
    end

    rst = s.rst; wb_valid_W = s.valid; ctrl_signals_W = s.ctrl; rd_W = s.rd;
    alu_result_W = s.alu; data_load_ext_W = s.ld; se_immediate_W = s.imm; pc_plus_4_W = s.pc4;
    ll_valid = s.llv; ll_rd = s.llrd; ll_data = s.lld;

    e.we = 1'b0; e.rd = '0; e.data = '0; e.busy = '0; e.pending = '0;
    for (int i = 0; i < N_LL; i++) begin
      rdy[i] = !s.rst && (mq[i].size() < DEPTH);
      e.pending[i*CW +: CW] = CW'(mq[i].size());
      foreach (mq[i][j]) e.busy |= 32'd1 << mq[i][j].rd;
    end
    e.busy[0] = 1'b0;
    e.ready = rdy;

    sel = -1;
    for (int i = 0; i < N_LL; i++) if (sel < 0 && m_age[i] == STARVE_LIMIT) sel = i;
    e.stall  = (sel >= 0);
    pipe_req = !s.rst && s.valid && s.ctrl.reg_write && (s.rd != 0);
    ll_gnt   = e.stall;
    if (!e.stall && pipe_req) begin
      e.we = 1'b1;
      e.rd = s.rd;
      e.data = s.ctrl.is_J_Rd ? s.pc4 : s.ctrl.is_Uinstr ? s.imm : s.ctrl.mem_to_reg ? s.ld : s.alu;
    end else if (!e.stall) begin
      for (int k = 1; k <= N_LL; k++) begin
        int c;
        c = (m_last + k) % N_LL;
        if (sel < 0 && mq[c].size() > 0) sel = c;
      end
      ll_gnt = (sel >= 0);
    end
    if (ll_gnt && mq[sel][0].rd != 0) begin
      e.we = 1'b1;
      e.rd = mq[sel][0].rd;
      e.data = mq[sel][0].data;
    end
    sb.push_back(e);

    if (!s.rst) begin
      for (int i = 0; i < N_LL; i++) begin
        if (ll_gnt && i == sel) begin
          void'(mq[i].pop_front());
          m_age[i] = 0;
        end else if (mq[i].size() == 0) m_age[i] = 0;
        else if (m_age[i] < STARVE_LIMIT) m_age[i]++;
      end
      if (ll_gnt) m_last = sel;
      for (int i = 0; i < N_LL; i++) begin
        if (s.llv[i] && rdy[i]) mq[i].push_back('{rd: s.llrd[i*5 +: 5], data: s.lld[i*XLEN +: XLEN]});
      end
      m_stall_prev = e.stall;
      m_held = s;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    int    guard;
    n_vec = 0; n_err = 0; m_last = 0; m_stall_prev = 1'b0;
    for (int i = 0; i < N_LL; i++) m_age[i] = 0;
    s = idle();
    wb_valid_W = 1'b0; ctrl_signals_W = '0; rd_W = '0;
    alu_result_W = '0; data_load_ext_W = '0; se_immediate_W = '0; pc_plus_4_W = '0;
    ll_valid = '0; ll_rd = '0; ll_data = '0;
    @(posedge clk);
    #1;

    // Reset state, including a pipe request while in reset.
    s = idle(); s.rst = 1'b1; cycle(s);
    s = pipe_w(3); s.rst = 1'b1; cycle(s);

    // Pipe only: load result to x5, then the same with rd=0.
    s = idle(); s.valid = 1'b1; s.ctrl.reg_write = 1'b1; s.ctrl.mem_to_reg = 1'b1;
    s.ld = 32'hDEAD_BEEF; s.alu = 32'h1234_5678; s.rd = 5'd5;
    cycle(s);
    s.rd = 5'd0;
    cycle(s);

    // Single LL completion on ch0 with the pipe idle.
    cycle(with_ll(idle(), 0, 5'd3, 32'h11));
    cycle(idle());
    cycle(idle());

    // Fill ch1 while the pipe writes every cycle until starvation forces a stall.
    for (int c = 0; c < 12; c++) begin
      s = pipe_w(c);
      if (c < 3) s = with_ll(s, 1, 5'(7 + c), 32'hA000_0000 + 32'(c));
      cycle(s);
    end
    for (int c = 0; c < 4; c++) cycle(idle());

    // Both channels loaded, then drained round-robin with the pipe idle.
    for (int c = 0; c < 2; c++) begin
      s = with_ll(pipe_w(c), 0, 5'(10 + c), 32'hB000_0000 + 32'(c));
      cycle(with_ll(s, 1, 5'(20 + c), 32'hC000_0000 + 32'(c)));
    end
    for (int c = 0; c < 6; c++) cycle(idle());

    // Push and pop on ch0 in the same cycle at count 1.
    cycle(with_ll(idle(), 0, 5'd4, 32'h44));
    cycle(with_ll(idle(), 0, 5'd6, 32'h66));
    cycle(idle());
    cycle(idle());

    // Reset while ch0 is full and its head is about to starve.
    for (int c = 0; c < 2; c++) cycle(with_ll(pipe_w(c), 0, 5'(12 + c), 32'hD000_0000 + 32'(c)));
    guard = 0;
    while (m_age[0] != STARVE_LIMIT && guard < 20) begin
      cycle(pipe_w(guard));
      guard++;
    end
    check("starve_reached", 64'(m_age[0]), 64'(STARVE_LIMIT));
    s = with_ll(pipe_w(9), 0, 5'd15, 32'hEE); s.rst = 1'b1;
    cycle(s);
    for (int c = 0; c < 3; c++) cycle(idle());

    // Randomized traffic with occasional mid-run resets.
    for (int c = 0; c < 1500; c++) begin
      s = rnd();
      if ($urandom_range(0, 149) == 0) s.rst = 1'b1;
      cycle(s);
    end
    cycle(idle());

    guard = 0;
    while (sb.size() != 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
